mcb_port_arbiter: RTL and testbench

- Shares one read/write MCB user port between two requesters, e.g. the data cache and a future DMA/blitter on port 0.
- Grants whole transactions (burst of 1-64 words) round-robin; owns write-data forwarding, command issue and read-data return for the granted requester.
- Holds off all grants until memory calibration completes.

---
 rtl/mcb_port_arbiter_pkg.sv | 36 +++
 rtl/mcb_port_arbiter_rr_arbiter2.sv | 19 +
 rtl/mcb_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mcb_port_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcb_port_arbiter_pkg.sv
// Shared definitions for the two-requester MCB user-port arbiter:
// MCB field widths, instruction codes, FSM encoding and the latched transaction record.
package mcb_port_arbiter_pkg;

    localparam int MCB_ADDR_BITS = 30;
    localparam int MCB_BL_BITS   = 6;
    localparam int MCB_DATA_BITS = 32;
    localparam int MCB_MASK_BITS = 4;

    localparam logic [2:0] MCB_WR_INSTR = 3'b000;
    localparam logic [2:0] MCB_RD_INSTR = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_CMD,
        ST_RDATA,
        ST_DONE
    } arb_state_t;

    typedef struct packed {
        logic                     we;
        logic [MCB_ADDR_BITS-1:0] addr;
        logic [MCB_BL_BITS-1:0]   bl;
    } txn_t;

    function automatic logic [1:0] owner_mask(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

    // The MCB user port is word-addressed in practice; byte offset bits are dropped.
    function automatic logic [MCB_ADDR_BITS-1:0] word_align(input logic [MCB_ADDR_BITS-1:0] addr);
        return {addr[MCB_ADDR_BITS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mcb_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, the requester that
// did not own the resource last wins a tie.
module mcb_port_arbiter_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last_owner ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mcb_port_arbiter.sv
// Shares one MCB read/write user port between two requesters, granting whole
// burst transactions round-robin once memory calibration has completed.
module mcb_port_arbiter
    import mcb_port_arbiter_pkg::*;
#(
    parameter logic [2:0] WR_INSTR = MCB_WR_INSTR,
    parameter logic [2:0] RD_INSTR = MCB_RD_INSTR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       calib_done,

    input  logic [1:0]                 req,
    input  logic [1:0]                 req_we,
    input  logic [2*MCB_ADDR_BITS-1:0] req_addr,
    input  logic [2*MCB_BL_BITS-1:0]   req_bl,
    input  logic [2*MCB_DATA_BITS-1:0] req_wr_data,
    input  logic [2*MCB_MASK_BITS-1:0] req_wr_mask,
    input  logic [1:0]                 req_wr_valid,
    output logic [1:0]                 req_wr_ready,
    output logic [1:0]                 gnt,
    output logic [1:0]                 done,
    output logic [MCB_DATA_BITS-1:0]   rd_data,
    output logic [1:0]                 rd_valid,

    output logic                       mem_cmd_en,
    output logic [2:0]                 mem_cmd_instr,
    output logic [MCB_BL_BITS-1:0]     mem_cmd_bl,
    output logic [MCB_ADDR_BITS-1:0]   mem_cmd_byte_addr,
    input  logic                       mem_cmd_full,

    output logic                       mem_wr_en,
    output logic [MCB_MASK_BITS-1:0]   mem_wr_mask,
    output logic [MCB_DATA_BITS-1:0]   mem_wr_data,
    input  logic                       mem_wr_full,

    output logic                       mem_rd_en,
    input  logic [MCB_DATA_BITS-1:0]   mem_rd_data,
    input  logic                       mem_rd_empty
);

    arb_state_t               state;
    txn_t                     txn;
    logic                     owner;
    logic                     last_owner;
    // One bit wider than the burst length so a 64-word burst never wraps the count.
    logic [MCB_BL_BITS:0]     word_cnt;

    logic [1:0]               arb_gnt;
    logic                     arb_owner;
    logic                     arb_fire;
    logic                     last_word;
    logic                     wr_accept;
    logic                     cmd_accept;
    logic                     rd_accept;
    logic [MCB_DATA_BITS-1:0] owner_wr_data;
    logic [MCB_MASK_BITS-1:0] owner_wr_mask;

    mcb_port_arbiter_rr_arbiter2 u_rr_arbiter2 (
        .req        (req),
        .last_owner (last_owner),
        .gnt        (arb_gnt)
    );

    assign arb_owner  = arb_gnt[1];
    assign arb_fire   = calib_done && (arb_gnt != 2'b00);
    assign last_word  = (word_cnt == {1'b0, txn.bl});
    assign wr_accept  = (state == ST_WDATA) && req_wr_valid[owner] && !mem_wr_full;
    assign cmd_accept = (state == ST_CMD) && !mem_cmd_full;
    assign rd_accept  = (state == ST_RDATA) && !mem_rd_empty;

    assign owner_wr_data = owner ? req_wr_data[2*MCB_DATA_BITS-1:MCB_DATA_BITS]
                                 : req_wr_data[MCB_DATA_BITS-1:0];
    assign owner_wr_mask = owner ? req_wr_mask[2*MCB_MASK_BITS-1:MCB_MASK_BITS]
                                 : req_wr_mask[MCB_MASK_BITS-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            txn        <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            word_cnt   <= '0;
            gnt        <= 2'b00;
            done       <= 2'b00;
        end else begin
            done <= 2'b00;
            unique case (state)
                ST_IDLE: begin
                    if (arb_fire) begin
                        owner    <= arb_owner;
                        txn.we   <= req_we[arb_owner];
                        txn.addr <= arb_owner ? req_addr[2*MCB_ADDR_BITS-1:MCB_ADDR_BITS]
                                              : req_addr[MCB_ADDR_BITS-1:0];
                        txn.bl   <= arb_owner ? req_bl[2*MCB_BL_BITS-1:MCB_BL_BITS]
                                              : req_bl[MCB_BL_BITS-1:0];
                        gnt      <= arb_gnt;
                        word_cnt <= '0;
                        state    <= req_we[arb_owner] ? ST_WDATA : ST_CMD;
                    end
                end
                ST_WDATA: begin
                    // The command is only issued once the whole burst sits in the write FIFO.
                    if (wr_accept) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) begin
                            state <= ST_CMD;
                        end
                    end
                end
                ST_CMD: begin
                    if (cmd_accept) begin
                        word_cnt <= '0;
                        if (txn.we) begin
                            state <= ST_DONE;
                            done  <= owner_mask(owner);
                        end else begin
                            state <= ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (rd_accept) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) begin
                            state <= ST_DONE;
                            done  <= owner_mask(owner);
                        end
                    end
                end
                ST_DONE: begin
                    gnt        <= 2'b00;
                    last_owner <= owner;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Port-facing strobes and data are gated by state so idle and reset present all zeros.
    always_comb begin
        req_wr_ready      = 2'b00;
        rd_valid          = 2'b00;
        rd_data           = '0;
        mem_cmd_en        = 1'b0;
        mem_cmd_instr     = 3'b000;
        mem_cmd_bl        = '0;
        mem_cmd_byte_addr = '0;
        mem_wr_en         = 1'b0;
        mem_wr_mask       = '0;
        mem_wr_data       = '0;
        mem_rd_en         = 1'b0;
        unique case (state)
            ST_WDATA: begin
                req_wr_ready[owner] = !mem_wr_full;
                mem_wr_en           = wr_accept;
                mem_wr_data         = owner_wr_data;
                mem_wr_mask         = owner_wr_mask;
            end
            ST_CMD: begin
                mem_cmd_en        = cmd_accept;
                mem_cmd_instr     = txn.we ? WR_INSTR : RD_INSTR;
                mem_cmd_bl        = txn.bl;
                mem_cmd_byte_addr = word_align(txn.addr);
            end
            ST_RDATA: begin
                mem_rd_en       = rd_accept;
                rd_valid[owner] = rd_accept;
                rd_data         = mem_rd_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Self-checking bench for mcb_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of the shared port.
module tb_mcb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        calib_done;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [59:0] req_addr;
    logic [11:0] req_bl;
    logic [63:0] req_wr_data;
    logic [7:0]  req_wr_mask;
    logic [1:0]  req_wr_valid;
    logic [1:0]  req_wr_ready;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [31:0] rd_data;
    logic [1:0]  rd_valid;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_cmd_full;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_wr_data;
    logic        mem_wr_full;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        mem_rd_empty;

    always #5 clk = ~clk;

    mcb_port_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .calib_done        (calib_done),
        .req               (req),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_bl            (req_bl),
        .req_wr_data       (req_wr_data),
        .req_wr_mask       (req_wr_mask),
        .req_wr_valid      (req_wr_valid),
        .req_wr_ready      (req_wr_ready),
        .gnt               (gnt),
        .done              (done),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .mem_cmd_en        (mem_cmd_en),
        .mem_cmd_instr     (mem_cmd_instr),
        .mem_cmd_bl        (mem_cmd_bl),
        .mem_cmd_byte_addr (mem_cmd_byte_addr),
        .mem_cmd_full      (mem_cmd_full),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_mask       (mem_wr_mask),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_full       (mem_wr_full),
        .mem_rd_en         (mem_rd_en),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_empty      (mem_rd_empty)
    );

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [5:0]  bl;
        logic [31:0] data [64];
        logic [3:0]  mask [64];
    } tb_txn_t;

    tb_txn_t tx [2];
    logic    model_last;
    bit      quiet;
    bit      wr_full_q[$];
    bit      cmd_full_q[$];
    bit      rd_empty_q[$];
    int      n_checks = 0;
    int      n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-robin rule: a lone requester wins; on a tie the one that did not go last wins.
    function automatic logic pick_owner(input logic [1:0] r, input logic last);
        if (r == 2'b11) return !last;
        return r[1];
    endfunction

    function automatic bit next_wr_full();
        if (wr_full_q.size() != 0) return wr_full_q.pop_front();
        if (quiet) return 1'b0;
        return ($urandom_range(0, 3) == 0);
    endfunction

    function automatic bit next_cmd_full();
        if (cmd_full_q.size() != 0) return cmd_full_q.pop_front();
        if (quiet) return 1'b0;
        return ($urandom_range(0, 2) == 0);
    endfunction

    function automatic bit next_rd_empty();
        if (rd_empty_q.size() != 0) return rd_empty_q.pop_front();
        if (quiet) return 1'b0;
        return ($urandom_range(0, 3) == 0);
    endfunction

    function automatic bit next_valid();
        if (quiet) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic gen_txn(input int i, input logic we, input logic [29:0] addr, input logic [5:0] bl);
        tx[i].we   = we;
        tx[i].addr = addr;
        tx[i].bl   = bl;
        for (int k = 0; k < 64; k++) begin
            tx[i].data[k] = $urandom;
            tx[i].mask[k] = 4'($urandom);
        end
    endtask

    task automatic rand_txn(input int i);
        logic [5:0] bl;
        bl = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
        gen_txn(i, 1'($urandom_range(0, 1)), 30'($urandom), bl);
    endtask

    task automatic apply_req();
        for (int i = 0; i < 2; i++) begin
            req_we[i]          = tx[i].we;
            req_addr[i*30 +: 30] = tx[i].addr;
            req_bl[i*6 +: 6]     = tx[i].bl;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {gnt, done, req_wr_ready, rd_valid, mem_cmd_en, mem_wr_en, mem_rd_en,
                              mem_cmd_instr, mem_cmd_bl, mem_wr_mask}, 64'd0);
        check({tag, "_addr"}, mem_cmd_byte_addr, 64'd0);
        check({tag, "_data"}, {rd_data, mem_wr_data}, 64'd0);
    endtask

    // Entered at posedge+1 of the arbitration cycle with req already driven; returns at
    // the negedge of the done cycle. cycles counts arbitration through done inclusive.
    task automatic run_txn(input logic o, input bit rearm, output int cycles);
        logic [1:0]  om;
        logic        exp_we;
        logic [5:0]  exp_bl;
        logic [29:0] exp_addr;
        int          phase, cur, words, wr_pulses, cmd_pulses, rd_pulses;
        bit          finished, exp_en;
        om         = o ? 2'b10 : 2'b01;
        exp_we     = tx[o].we;
        exp_bl     = tx[o].bl;
        exp_addr   = tx[o].addr & 30'h3FFF_FFFC;
        phase      = exp_we ? 0 : 1;
        words      = 0;
        wr_pulses  = 0;
        cmd_pulses = 0;
        rd_pulses  = 0;
        finished   = 1'b0;
        cycles     = 1;
        calib_done = 1'b1;
        apply_req();
        @(negedge clk);
        check("arb_cycle_gnt", gnt, 2'b00);
        while (!finished && cycles < 600) begin
            @(posedge clk);
            #1;
            cycles++;
            cur          = phase;
            calib_done   = 1'($urandom_range(0, 1));
            mem_wr_full  = (cur == 0) ? next_wr_full()  : 1'($urandom_range(0, 1));
            mem_cmd_full = (cur == 1) ? next_cmd_full() : 1'($urandom_range(0, 1));
            mem_rd_empty = (cur == 2) ? next_rd_empty() : 1'($urandom_range(0, 1));
            mem_rd_data  = $urandom;
            req_wr_valid = 2'($urandom_range(0, 3));
            req_wr_data  = {$urandom, $urandom};
            req_wr_mask  = 8'($urandom);
            if (cur == 0) begin
                req_wr_valid[o]       = next_valid();
                req_wr_data[o*32 +: 32] = tx[o].data[words];
                req_wr_mask[o*4 +: 4]   = tx[o].mask[words];
            end
            if (cur == 3) begin
                if (rearm) begin
                    rand_txn(int'(o));
                    apply_req();
                end else begin
                    req[o] = 1'b0;
                end
            end
            @(negedge clk);
            if (mem_wr_en)  wr_pulses++;
            if (mem_cmd_en) cmd_pulses++;
            if (mem_rd_en)  rd_pulses++;
            check("gnt_held", gnt, om);
            if (cur != 3) check("done_early", done, 2'b00);
            case (cur)
                0: begin
                    check("wr_ready", req_wr_ready, mem_wr_full ? 2'b00 : om);
                    exp_en = req_wr_valid[o] && !mem_wr_full;
                    check("wr_en", mem_wr_en, exp_en);
                    check("cmd_before_data", mem_cmd_en, 1'b0);
                    check("rd_valid_in_wdata", rd_valid, 2'b00);
                    if (exp_en) begin
                        check("wr_data", mem_wr_data, tx[o].data[words]);
                        check("wr_mask", mem_wr_mask, tx[o].mask[words]);
                        words++;
                        if (words == exp_bl + 1) phase = 1;
                    end
                end
                1: begin
                    check("ready_in_cmd", req_wr_ready, 2'b00);
                    check("wr_en_in_cmd", mem_wr_en, 1'b0);
                    check("rd_en_in_cmd", mem_rd_en, 1'b0);
                    exp_en = !mem_cmd_full;
                    check("cmd_en", mem_cmd_en, exp_en);
                    if (exp_en) begin
                        check("cmd_instr", mem_cmd_instr, exp_we ? 3'b000 : 3'b001);
                        check("cmd_bl", mem_cmd_bl, exp_bl);
                        check("cmd_addr", mem_cmd_byte_addr, exp_addr);
                        phase = exp_we ? 3 : 2;
                        words = 0;
                    end
                end
                2: begin
                    check("rd_en", mem_rd_en, !mem_rd_empty);
                    check("rd_valid", rd_valid, mem_rd_empty ? 2'b00 : om);
                    check("cmd_en_in_rdata", mem_cmd_en, 1'b0);
                    if (!mem_rd_empty) begin
                        check("rd_data", rd_data, mem_rd_data);
                        words++;
                        if (words == exp_bl + 1) phase = 3;
                    end
                end
                default: begin
                    check("done_pulse", done, om);
                    check("wr_pulse_total", wr_pulses, exp_we ? exp_bl + 1 : 0);
                    check("cmd_pulse_total", cmd_pulses, 1);
                    check("rd_pulse_total", rd_pulses, exp_we ? 0 : exp_bl + 1);
                    finished = 1'b1;
                end
            endcase
        end
        if (!finished) check("txn_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = 2'b00;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        model_last = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot_gnt", $countones(gnt) <= 1, 1'b1);
            check("onehot_rd_valid", $countones(rd_valid) <= 1, 1'b1);
            check("onehot_wr_ready", $countones(req_wr_ready) <= 1, 1'b1);
        end
    end

    initial begin
        int          cyc;
        logic        o;
        logic [1:0]  mask;
        logic        exp_order [4];
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst_n        = 1'b0;
        calib_done   = 1'b1;
        req          = 2'b11;
        req_we       = 2'b11;
        req_addr     = {$urandom, $urandom};
        req_bl       = 12'hFFF;
        req_wr_data  = {$urandom, $urandom};
        req_wr_mask  = 8'hFF;
        req_wr_valid = 2'b11;
        mem_cmd_full = 1'b0;
        mem_wr_full  = 1'b0;
        mem_rd_empty = 1'b0;
        mem_rd_data  = 32'hDEAD_BEEF;
        quiet        = 1'b1;
        model_last   = 1'b1;
        #12;
        check_all_zero("reset");
        req = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single-word write latency
        @(posedge clk);
        #1;
        gen_txn(0, 1'b1, 30'h0000_0100, 6'd0);
        req = 2'b01;
        run_txn(1'b0, 1'b0, cyc);
        check("latency_1word_write", cyc, 4);
        model_last = 1'b0;

        // requester 0 four-word write, unaligned address
        @(posedge clk);
        #1;
        gen_txn(0, 1'b1, 30'h0000_1236, 6'd3);
        req = 2'b01;
        run_txn(1'b0, 1'b0, cyc);
        check("latency_4word_write", cyc, 7);

        // requester 1 two-word read with a bubble in the read FIFO
        @(posedge clk);
        #1;
        rd_empty_q = '{1'b0, 1'b1, 1'b0};
        gen_txn(1, 1'b0, 30'h0000_0a0b, 6'd1);
        req = 2'b10;
        run_txn(1'b1, 1'b0, cyc);
        check("latency_read_bubble", cyc, 6);
        model_last = 1'b1;

        // fairness from reset with both requesters continuously busy
        quiet = 1'b0;
        do_reset();
        @(posedge clk);
        #1;
        rand_txn(0);
        rand_txn(1);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            run_txn(exp_order[k], k < 2, cyc);
        end
        model_last = 1'b1;

        // write FIFO full then command FIFO full
        quiet      = 1'b1;
        wr_full_q  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        cmd_full_q = '{1'b1, 1'b1, 1'b1};
        @(posedge clk);
        #1;
        gen_txn(0, 1'b1, 30'h0123_4567, 6'd2);
        req = 2'b01;
        run_txn(1'b0, 1'b0, cyc);
        check("latency_backpressure", cyc, 14);
        model_last = 1'b0;

        // maximum bursts on both requesters
        quiet = 1'b0;
        @(posedge clk);
        #1;
        gen_txn(0, 1'b0, 30'h2aaa_aaab, 6'd63);
        gen_txn(1, 1'b1, 30'h1555_5555, 6'd63);
        req = 2'b11;
        o   = pick_owner(req, model_last);
        run_txn(o, 1'b0, cyc);
        model_last = o;
        @(posedge clk);
        #1;
        o = pick_owner(req, model_last);
        run_txn(o, 1'b0, cyc);
        model_last = o;

        // no grant while calibration is incomplete
        @(posedge clk);
        #1;
        calib_done = 1'b0;
        rand_txn(0);
        rand_txn(1);
        apply_req();
        req = 2'b11;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("calib_hold_gnt", gnt, 2'b00);
            @(posedge clk);
            #1;
        end
        o = pick_owner(req, model_last);
        run_txn(o, 1'b0, cyc);
        model_last = o;
        @(posedge clk);
        #1;
        o = pick_owner(req, model_last);
        run_txn(o, 1'b0, cyc);
        model_last = o;

        // asynchronous reset in the middle of a read burst
        quiet = 1'b1;
        @(posedge clk);
        #1;
        gen_txn(0, 1'b0, 30'h0000_2000, 6'd5);
        apply_req();
        calib_done   = 1'b1;
        mem_cmd_full = 1'b0;
        mem_rd_empty = 1'b1;
        req          = 2'b01;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_seq_cmd_en", mem_cmd_en, 1'b1);
        @(posedge clk);
        #1;
        mem_rd_empty = 1'b0;
        mem_rd_data  = $urandom;
        @(negedge clk);
        check("rst_seq_rd_valid", rd_valid, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_rdata");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        model_last = 1'b1;
        run_txn(1'b0, 1'b0, cyc);
        model_last = 1'b0;

        // randomized traffic
        quiet = 1'b0;
        for (int r = 0; r < 30; r++) begin
            if (req == 2'b00) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                    calib_done = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    check("idle_gnt", gnt, 2'b00);
                end
                @(posedge clk);
                #1;
                mask = 2'($urandom_range(1, 3));
                for (int i = 0; i < 2; i++) begin
                    if (mask[i]) rand_txn(i);
                end
                req = mask;
            end else begin
                @(posedge clk);
                #1;
            end
            o = pick_owner(req, model_last);
            run_txn(o, 1'($urandom_range(0, 1)), cyc);
            model_last = o;
        end
        for (int k = 0; k < 2 && req != 2'b00; k++) begin
            @(posedge clk);
            #1;
            o = pick_owner(req, model_last);
            run_txn(o, 1'b0, cyc);
            model_last = o;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
